// File: rtl/i8to1_16bit_if.sv
// Bundle of select, data sources, capture strobe and mux results for the
// 8-to-1 word selector.
interface i8to1_16bit_if #(
   parameter int WIDTH = 16
);
   logic [2:0]       S;
   logic [WIDTH-1:0] in0;
   logic [WIDTH-1:0] in1;
   logic [WIDTH-1:0] in2;
   logic [WIDTH-1:0] in3;
   logic [WIDTH-1:0] in4;
   logic [WIDTH-1:0] in5;
   logic [WIDTH-1:0] in6;
   logic [WIDTH-1:0] in7;
   logic             en;
   logic [WIDTH-1:0] Y;
   logic [WIDTH-1:0] Y_q;
   logic [2:0]       S_q;
   logic             vld;

   modport master (
      output S, in0, in1, in2, in3, in4, in5, in6, in7, en,
      input  Y, Y_q, S_q, vld
   );

   modport slave (
      input  S, in0, in1, in2, in3, in4, in5, in6, in7, en,
      output Y, Y_q, S_q, vld
   );
endinterface

// File: rtl/i8to1_16bit.sv
// 8-to-1 word selector: combinational result Y plus a registered copy
// (Y_q, S_q) captured on en, with vld flagging the cycle after a capture.
module i8to1_16bit #(
   parameter int WIDTH = 16
) (
   input logic           clk,
   input logic           rst,
   i8to1_16bit_if.slave  bus
);

   logic [WIDTH-1:0] mux_y;
   logic [WIDTH-1:0] y_d, y_q;
   logic [2:0]       s_d, s_q;
   logic             vld_d, vld_q;

   always_comb begin
      mux_y = '0;
      case (bus.S)
         3'd0: mux_y = bus.in0;
         3'd1: mux_y = bus.in1;
         3'd2: mux_y = bus.in2;
         3'd3: mux_y = bus.in3;
         3'd4: mux_y = bus.in4;
         3'd5: mux_y = bus.in5;
         3'd6: mux_y = bus.in6;
         3'd7: mux_y = bus.in7;
      endcase
   end

   always_comb begin
      y_d   = y_q;
      s_d   = s_q;
      vld_d = bus.en;
      if (bus.en) begin
         y_d = mux_y;
         s_d = bus.S;
      end
   end

   // Capture stage: reset wipes any capture pending at the next edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y_q   <= '0;
         s_q   <= 3'd0;
         vld_q <= 1'b0;
      end else begin
         y_q   <= y_d;
         s_q   <= s_d;
         vld_q <= vld_d;
      end
   end

   assign bus.Y   = mux_y;
   assign bus.Y_q = y_q;
   assign bus.S_q = s_q;
   assign bus.vld = vld_q;

endmodule

// File: tb/tb_i8to1_16bit.sv
// Directed and randomized checks of the 8-to-1 selector against an
// array-indexed reference of the selection and capture behaviour.
module tb_i8to1_16bit;
   localparam int WIDTH = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [2:0]       sel = 3'd0;
   logic             en  = 1'b0;
   logic [WIDTH-1:0] din [8];

   int checks   = 0;
   int failures = 0;

   logic [WIDTH-1:0] exp_yq;
   logic [2:0]       exp_sq;
   logic             exp_vld;

   i8to1_16bit_if #(.WIDTH(WIDTH)) bus ();

   assign bus.S   = sel;
   assign bus.en  = en;
   assign bus.in0 = din[0];
   assign bus.in1 = din[1];
   assign bus.in2 = din[2];
   assign bus.in3 = din[3];
   assign bus.in4 = din[4];
   assign bus.in5 = din[5];
   assign bus.in6 = din[6];
   assign bus.in7 = din[7];

   i8to1_16bit #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic load_pattern;
      for (int i = 0; i < 8; i++) din[i] = 16'((i + 1) * 16'h1111);
   endtask

   initial begin
      for (int i = 0; i < 8; i++) din[i] = 16'h0000;

      // Reset state, and reset dominating an en=1 edge
      #1 rst = 1'b1;
      #1;
      chk("rst_yq", bus.Y_q, 16'h0000);
      chk("rst_sq", 16'(bus.S_q), 16'h0000);
      chk("rst_vld", 16'(bus.vld), 16'h0000);
      din[5] = 16'h5A5A;
      sel = 3'd5;
      en  = 1'b1;
      tick;
      chk("rst_en_yq", bus.Y_q, 16'h0000);
      chk("rst_en_vld", 16'(bus.vld), 16'h0000);
      chk("rst_y_live", bus.Y, 16'h5A5A);
      en  = 1'b0;
      rst = 1'b0;

      // Select sweep with 5 ns steps
      load_pattern();
      for (int s = 0; s < 8; s++) begin
         sel = 3'(s);
         #5;
         chk($sformatf("sweep_S%0d", s), bus.Y, 16'((s + 1) * 16'h1111));
      end

      // Non-selected input toggling leaves Y alone
      sel = 3'd3;
      din[3] = 16'hABCD;
      for (int k = 0; k < 4; k++) begin
         din[5] = 16'($urandom);
         #1;
         chk("unsel_toggle", bus.Y, 16'hABCD);
      end

      // Single capture then hold
      @(posedge clk);
      #1;
      sel = 3'd6;
      din[6] = 16'hBEEF;
      en = 1'b1;
      tick;
      en = 1'b0;
      chk("cap_yq", bus.Y_q, 16'hBEEF);
      chk("cap_sq", 16'(bus.S_q), 16'h0006);
      chk("cap_vld", 16'(bus.vld), 16'h0001);
      tick;
      chk("hold_vld", 16'(bus.vld), 16'h0000);
      chk("hold_yq", bus.Y_q, 16'hBEEF);
      chk("hold_sq", 16'(bus.S_q), 16'h0006);

      // Back-to-back captures
      load_pattern();
      en = 1'b1;
      for (int s = 0; s < 3; s++) begin
         sel = 3'(s);
         tick;
         chk($sformatf("b2b_yq%0d", s), bus.Y_q, 16'((s + 1) * 16'h1111));
         chk($sformatf("b2b_vld%0d", s), 16'(bus.vld), 16'h0001);
      end

      // Asynchronous reset between edges with a capture pending
      sel = 3'd7;
      tick;
      chk("pre_rst_yq", bus.Y_q, 16'h8888);
      #3 rst = 1'b1;
      #1;
      chk("arst_yq", bus.Y_q, 16'h0000);
      chk("arst_sq", 16'(bus.S_q), 16'h0000);
      chk("arst_vld", 16'(bus.vld), 16'h0000);
      chk("arst_y", bus.Y, 16'h8888);
      tick;
      chk("arst_edge_yq", bus.Y_q, 16'h0000);
      chk("arst_edge_vld", 16'(bus.vld), 16'h0000);

      // First capture after release
      rst = 1'b0;
      sel = 3'd2;
      tick;
      chk("post_rst_yq", bus.Y_q, 16'h3333);
      chk("post_rst_sq", 16'(bus.S_q), 16'h0002);
      chk("post_rst_vld", 16'(bus.vld), 16'h0001);
      en = 1'b0;
      din[2] = 16'($urandom);
      sel = 3'd4;
      tick;
      chk("en0_hold_yq", bus.Y_q, 16'h3333);
      chk("en0_vld", 16'(bus.vld), 16'h0000);

      // Randomized run against the reference
      exp_yq  = 16'h3333;
      exp_sq  = 3'd2;
      exp_vld = 1'b0;
      for (int c = 0; c < 1000; c++) begin
         for (int i = 0; i < 8; i++) din[i] = 16'($urandom);
         if (c == 0) din[0] = 16'h3524;
         sel = 3'($urandom_range(0, 7));
         en  = ($urandom_range(0, 3) != 0);
         #1;
         chk("rand_y", bus.Y, din[sel]);
         if (en) begin
            exp_yq = din[sel];
            exp_sq = sel;
         end
         exp_vld = en;
         tick;
         chk("rand_yq", bus.Y_q, exp_yq);
         chk("rand_sq", 16'(bus.S_q), 16'(exp_sq));
         chk("rand_vld", 16'(bus.vld), 16'(exp_vld));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/i8to1_16bit.md
I8TO1_16BIT -- requirements
Module: i8to1_16bit

Interface
REQ-001 Parameter: WIDTH, 16, data width of every data input and output; all requirements assume 16.
REQ-002 clk  input  1  single system clock; all registers update on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset; clears all registers immediately, independent of clk.
REQ-004 S  input  3  select code, unsigned, 0..7.
REQ-005 in0..in7  input  16 each  data sources; inN is selected when S == N.
REQ-006 en  input  1  capture strobe; when high at a rising clk edge, the selected word is registered.
REQ-007 Y  output  16  combinational mux result.
REQ-008 Y_q  output  16  registered mux result.
REQ-009 S_q  output  3  select code captured with Y_q.
REQ-010 vld  output  1  high for the cycle after a capture.

Function
REQ-011 Y SHALL equal in[S] combinationally at all times, with no clock dependence and no latch inference.
REQ-012 Y SHALL be unaffected by rst, en and clk.
REQ-013 Y SHALL follow any change on S or the selected input within the same delta/settle time.
REQ-014 Changes on a non-selected input SHALL NOT change Y.
REQ-015 Every 3-bit S value SHALL be decoded explicitly; no X propagation for defined S.
REQ-016 At a rising clk edge with en=1 and rst=0, Y_q SHALL load in[S] and S_q SHALL load S (latency 1 cycle).
REQ-017 At a rising clk edge with en=0 and rst=0, Y_q and S_q SHALL hold their values.
REQ-018 vld SHALL be en registered: vld=1 in the cycle after an en=1 edge, otherwise 0.
REQ-019 Back-to-back en=1 cycles SHALL capture each cycle's selection, with vld staying high continuously.
REQ-020 S and data changing in the same cycle as en=1 SHALL be captured using their values at the edge.
REQ-021 The block SHALL contain no arithmetic; all data paths are pure selection with WIDTH bits and no truncation or extension.

Reset
REQ-022 While rst=1, Y_q SHALL be 16'h0000, S_q SHALL be 3'b000 and vld SHALL be 0, regardless of clk and en.
REQ-023 Assertion of rst mid-operation SHALL clear the registers immediately (asynchronously), discarding any pending capture.
REQ-024 The first capture after reset release SHALL occur at the first rising edge with rst=0 and en=1.
REQ-025 The combinational output Y SHALL remain valid during reset.

Verification
REQ-026 Setup: in0=16'h1111, in1=16'h2222, in2=16'h3333, in3=16'h4444, in4=16'h5555, in5=16'h6666, in6=16'h7777, in7=16'h8888; sweep S 0->7 with a 5 ns step -> Y SHALL equal the corresponding inN at each step.
REQ-027 Setup: S=3, in3=16'hABCD; toggle in5 -> Y SHALL stay 16'hABCD.
REQ-028 Setup: S=6, in6=16'hBEEF, en=1 for one edge -> next cycle Y_q=16'hBEEF, S_q=6, vld=1; following cycle with en=0 -> vld=0 and Y_q holds 16'hBEEF.
REQ-029 Setup: en=1 for three consecutive edges with S=0,1,2 -> Y_q SHALL be 16'h1111, 16'h2222, 16'h3333 in successive cycles, with vld continuously 1.
REQ-030 Setup: after a capture of 16'h8888, assert rst between clock edges -> Y_q=0, S_q=0, vld=0 immediately, while Y still equals in[S].
REQ-031 Setup: random inputs (for example in0=16'h3524) and S random each cycle for 1000 cycles -> Y and Y_q SHALL match a reference model with 1-cycle latency on Y_q.
